dcm_prog_responder: RTL and testbench

DCM_PROG_RESPONDER -- requirements
Module: dcm_prog_responder

---
 rtl/dcm_prog_responder_pkg.sv | 24 ++
 rtl/dcm_prog_responder_shifter.sv | 30 +++
 rtl/dcm_prog_responder.sv | 171 +++++++++++++++++
 tb/tb_dcm_prog_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dcm_prog_responder_pkg.sv
// Shared definitions for the DCM programming-port responder:
// command encodings, error codes and FSM state enumeration.
package dcm_prog_responder_pkg;

  localparam logic [1:0] CMD_LOAD_D = 2'b10;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;
  localparam logic       CMD_GO     = 1'b0;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_CMD = 2'd1,
    ERR_BAD_LEN = 2'd2,
    ERR_BUSY    = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    DATA  = 3'd2,
    CHECK = 3'd3,
    DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/dcm_prog_responder_shifter.sv
// dcm_prog_shifter: 8-bit LSB-first serial-in shift register with a
// 3-bit bit counter and a flag that is set once all 8 bits are in.
module dcm_prog_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       din,
  output logic [7:0] data,
  output logic [2:0] bit_cnt,
  output logic       full
);

  // Shift new bits in at the MSB so the first bit lands in data[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= 8'h00;
      bit_cnt <= 3'd0;
      full    <= 1'b0;
    end else if (clr) begin
      bit_cnt <= 3'd0;
      full    <= 1'b0;
    end else if (shift_en) begin
      data    <= {din, data[7:1]};
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) full <= 1'b1;
    end
  end

endmodule

// File: rtl/dcm_prog_responder.sv
// DCM programming-port responder: decodes LoadD / LoadM / GO frames,
// holds pending and active M-1 / D-1, and models the relock delay.
// Optional frame/error statistics outputs: define DCM_RESP_STATS_EN.
//
// state | meaning
// IDLE  | waiting for en; rejects a frame start while relocking
// CMD   | first bit captured, deciding GO / Load / bad command
// DATA  | shifting 8 data bits
// CHECK | all data in, expecting en to drop
// DRAIN | error seen, waiting for en to drop
module dcm_prog_responder
  import dcm_prog_responder_pkg::*;
#(
  parameter int INITIAL_MULTIPLIER = 60,
  parameter int INITIAL_DIVIDER    = 10,
  parameter int LOCK_DELAY         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dcm_prog_en,
  input  logic       dcm_prog_data,
  output logic       dcm_prog_done,
  output logic [7:0] active_m1,
  output logic [7:0] active_d1,
  output logic       commit,
  output logic       frame_err,
  output logic [1:0] err_code
`ifdef DCM_RESP_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
`endif
);

  localparam logic [7:0] M1_RST    = 8'(INITIAL_MULTIPLIER - 1);
  localparam logic [7:0] D1_RST    = 8'(INITIAL_DIVIDER - 1);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCK_DELAY);

  state_e     state_q, state_d;
  logic       first_bit_q, is_m_q;
  logic [7:0] pend_m1_q, pend_d1_q;
  logic [7:0] lock_cnt_q;
  logic [7:0] sh_data;
  logic [2:0] sh_cnt;
  logic       sh_full;
  logic       err_set, go, wr_pend;
  err_code_e  err_val;

  dcm_prog_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q != DATA),
    .shift_en ((state_q == DATA) && dcm_prog_en),
    .din      (dcm_prog_data),
    .data     (sh_data),
    .bit_cnt  (sh_cnt),
    .full     (sh_full)
  );

  assign dcm_prog_done = (state_q == IDLE) && (lock_cnt_q == 8'd0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    err_val = ERR_NONE;
    go      = 1'b0;
    wr_pend = 1'b0;
    case (state_q)
      IDLE: if (dcm_prog_en) begin
        if (lock_cnt_q != 8'd0) begin
          err_set = 1'b1;
          err_val = ERR_BUSY;
          state_d = DRAIN;
        end else begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (!dcm_prog_en) begin
          if (first_bit_q == CMD_GO) go = 1'b1;
          else begin
            err_set = 1'b1;
            err_val = ERR_BAD_CMD;
          end
          state_d = IDLE;
        end else if (first_bit_q == CMD_GO) begin
          err_set = 1'b1;
          err_val = ERR_BAD_CMD;
          state_d = DRAIN;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (!dcm_prog_en) begin
          err_set = 1'b1;
          err_val = ERR_BAD_LEN;
          state_d = IDLE;
        end else if (sh_cnt == 3'd7) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!dcm_prog_en) begin
          wr_pend = sh_full;
          state_d = IDLE;
        end else begin
          err_set = 1'b1;
          err_val = ERR_BAD_LEN;
          state_d = DRAIN;
        end
      end
      DRAIN: if (!dcm_prog_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, pending/active registers, lock timer and error reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_bit_q <= 1'b0;
      is_m_q      <= 1'b0;
      pend_m1_q   <= M1_RST;
      pend_d1_q   <= D1_RST;
      active_m1   <= M1_RST;
      active_d1   <= D1_RST;
      lock_cnt_q  <= 8'd0;
      commit      <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      if (state_q == IDLE && dcm_prog_en) first_bit_q <= dcm_prog_data;
      if (state_q == CMD && dcm_prog_en)  is_m_q      <= dcm_prog_data;
      if (wr_pend) begin
        if ({first_bit_q, is_m_q} == CMD_LOAD_M) pend_m1_q <= sh_data;
        else                                     pend_d1_q <= sh_data;
      end
      if (go) begin
        active_m1  <= pend_m1_q;
        active_d1  <= pend_d1_q;
        lock_cnt_q <= LOCK_LOAD;
      end else if (lock_cnt_q != 8'd0) begin
        lock_cnt_q <= lock_cnt_q - 8'd1;
      end
      commit    <= go;
      frame_err <= err_set;
      if (err_set) err_code <= err_val;
    end
  end

`ifdef DCM_RESP_STATS_EN
  // Saturating counters of accepted frames and rejected frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 16'h0000;
      err_count   <= 16'h0000;
    end else begin
      if ((go || wr_pend) && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      if (err_set && err_count != 16'hFFFF)           err_count   <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcm_prog_responder.sv
// Self-checking bench for dcm_prog_responder: expected commit/error events
// are queued as frames are driven and compared when the DUT pulses.
module tb_dcm_prog_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dcm_prog_en = 1'b0;
  logic       dcm_prog_data = 1'b0;
  logic       dcm_prog_done;
  logic [7:0] active_m1, active_d1;
  logic       commit, frame_err;
  logic [1:0] err_code;
`ifdef DCM_RESP_STATS_EN
  logic [15:0] frame_count, err_count;
`endif

  dcm_prog_responder dut (
    .clk           (clk),
    .rst           (rst),
    .dcm_prog_en   (dcm_prog_en),
    .dcm_prog_data (dcm_prog_data),
    .dcm_prog_done (dcm_prog_done),
    .active_m1     (active_m1),
    .active_d1     (active_d1),
    .commit        (commit),
    .frame_err     (frame_err),
    .err_code      (err_code)
`ifdef DCM_RESP_STATS_EN
    ,
    .frame_count   (frame_count),
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [7:0] m1;
    logic [7:0] d1;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pm = 8'd59, pd = 8'd9, am = 8'd59, ad = 8'd9;
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, commit_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (commit || frame_err)) begin
      if (commit) commit_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, commit, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.is_err) begin
          chk("err_pulse", {31'd0, frame_err}, 32'd1);
          chk("err_code", {30'd0, err_code}, {30'd0, e.code});
        end else begin
          chk("commit_pulse", {31'd0, commit}, 32'd1);
        end
        chk("active_m1", {24'd0, active_m1}, {24'd0, e.m1});
        chk("active_d1", {24'd0, active_d1}, {24'd0, e.d1});
      end
    end
  end

  task automatic send_bits(input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      dcm_prog_en   = 1'b1;
      dcm_prog_data = bits[i];
    end
    @(negedge clk);
    dcm_prog_en   = 1'b0;
    dcm_prog_data = 1'b0;
  endtask

  task automatic load_ok(input logic is_m, input logic [7:0] val);
    send_bits({6'b0, val, is_m, 1'b1}, 10);
    if (is_m) pm = val;
    else      pd = val;
  endtask

  task automatic bad_frame(input logic [15:0] bits, input int len, input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.m1 = am; e.d1 = ad;
    sb.push_back(e);
    send_bits(bits, len);
  endtask

  task automatic go_nowait();
    exp_t e;
    am = pm; ad = pd;
    e.is_err = 1'b0; e.code = 2'd0; e.m1 = am; e.d1 = ad;
    sb.push_back(e);
    send_bits(16'h0000, 1);
  endtask

  task automatic wait_lock(input string tag);
    int n = 0;
    while (!dcm_prog_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, dcm_prog_done}, 32'd1);
    chk({tag, "_lock_len"}, cyc - commit_cyc, 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m1", {24'd0, active_m1}, 32'd59);
    chk("rst_d1", {24'd0, active_d1}, 32'd9);
    chk("rst_done", {31'd0, dcm_prog_done}, 32'd1);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);

    // Basic load and commit.
    load_ok(1'b0, 8'd9);
    load_ok(1'b1, 8'd71);
    go_nowait();
    wait_lock("go1");

    // Truncated LoadM leaves the earlier pending value in place.
    load_ok(1'b1, 8'd100);
    bad_frame({6'b0, 8'h3C, 1'b1, 1'b1}, 7, 2'd2);
    go_nowait();
    wait_lock("go2");

    // Bad command 0,1 drains, then a valid LoadM is accepted.
    bad_frame(16'h0006, 4, 2'd1);
    load_ok(1'b1, 8'd39);
    go_nowait();
    wait_lock("go3");

    // Length-1 frame with bit 1, overlong LoadD, boundary data codes.
    bad_frame(16'h0001, 1, 2'd1);
    bad_frame({5'b0, 1'b1, 8'hA5, 1'b0, 1'b1}, 11, 2'd2);
    load_ok(1'b1, 8'd255);
    load_ok(1'b0, 8'd0);
    go_nowait();
    wait_lock("go4");

    // LoadM started 3 cycles after GO is rejected as busy.
    load_ok(1'b1, 8'd20);
    go_nowait();
    repeat (2) @(negedge clk);
    bad_frame({6'b0, 8'd87, 1'b1, 1'b1}, 10, 2'd3);
    wait_lock("go_busy");
    go_nowait();
    wait_lock("go_after_busy");

    // Reset in the middle of LoadD 200 (after 4 data bits).
    load_ok(1'b0, 8'd33);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dcm_prog_en   = 1'b1;
      dcm_prog_data = (i == 0) ? 1'b1 : (i == 5) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    dcm_prog_en   = 1'b0;
    dcm_prog_data = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pm = 8'd59; pd = 8'd9; am = 8'd59; ad = 8'd9;
    @(negedge clk);
    chk("mrst_m1", {24'd0, active_m1}, 32'd59);
    chk("mrst_d1", {24'd0, active_d1}, 32'd9);
    chk("mrst_done", {31'd0, dcm_prog_done}, 32'd1);
    chk("mrst_err_code", {30'd0, err_code}, 32'd0);
    go_nowait();
    wait_lock("go_post_rst");

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
